// File: rtl/wb_arbiter_pkg.sv
// wb_arbiter_pkg: shared config for the write-back stage.
// Width defaults, priority modes, channel numbers, rr helper.
package wb_arbiter_pkg;

  localparam int xlen_def     = 32;
  localparam int rfidxlen_def = 5;

  typedef enum int {
    WB_PRIO_FIXED = 0,
    WB_PRIO_RR    = 1
  } wb_prio_e;

  typedef enum int {
    WB_CH_ALU = 0,
    WB_CH_MDU = 1,
    WB_CH_LSU = 2
  } wb_ch_e;

  // i-th channel visited by a round-robin search after ptr
  function automatic int rr_chan(
    input int ptr,
    input int i,
    input int n
  );
    return (ptr + 1 + i) % n;
  endfunction

endpackage

// File: rtl/wb_chan_fifo.sv
// wb_chan_fifo: per-channel result queue, wrap-bit pointers.
// Ports: push/wdata in, pop, clr (sync clear), full/empty/count/head.
module wb_chan_fifo
  import wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int W = rfidxlen_def + xlen_def,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          i_clk,
  input  logic          i_rstn,
  input  logic          push,
  input  logic          pop,
  input  logic          clr,
  input  logic [W-1:0]  wdata,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count,
  output logic [W-1:0]  head
);

  logic [AW:0]   wptr_q, wptr_d;
  logic [AW:0]   rptr_q, rptr_d;
  logic [AW-1:0] waddr, raddr, diff;
  logic [W-1:0]  mem_q [DEPTH];

  // pointer = {wrap, addr}; wrap flips when addr passes DEPTH-1
  function automatic logic [AW:0] ptr_inc(input logic [AW:0] p);
    if (p[AW-1:0] == AW'(DEPTH - 1)) begin
      return {~p[AW], {AW{1'b0}}};
    end
    return p + 1'b1;
  endfunction

  assign waddr = wptr_q[AW-1:0];
  assign raddr = rptr_q[AW-1:0];
  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (waddr == raddr);
  assign diff  = waddr - raddr;
  assign count = full ? CW'(DEPTH) : CW'(diff);
  assign head  = mem_q[raddr];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (clr) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (push) wptr_d = ptr_inc(wptr_q);
      if (pop)  rptr_d = ptr_inc(rptr_q);
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push && !clr) mem_q[waddr] <= wdata;
  end

endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: write-back stage, NCH queued producers -> NPORT rf ports.
// Ports: ch valid/ready/rdidx/wdata, flush, wb wen/rdidx/wdata, wait, jump regs.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int NCH = 3,
  parameter int DEPTH = 2,
  parameter int NPORT = 1,
  parameter int XLEN = xlen_def,
  parameter int RFIDXW = rfidxlen_def,
  parameter logic [NCH-1:0] FLUSHMASK = NCH'(1),
  parameter int PRIO_MODE = WB_PRIO_FIXED
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  i_flush,
  input  logic [NCH-1:0]        i_ch_valid,
  output logic [NCH-1:0]        o_ch_ready,
  input  logic [NCH*RFIDXW-1:0] i_ch_rdidx,
  input  logic [NCH*XLEN-1:0]   i_ch_wdata,
  input  logic                  i_exu_taken,
  input  logic [XLEN-1:0]       i_exu_jaddr,
  output logic                  o_exu_taken,
  output logic [XLEN-1:0]       o_exu_jaddr,
  output logic                  o_wait,
  output logic [NPORT-1:0]      o_wb_wen,
  output logic [NPORT*RFIDXW-1:0] o_wb_rdidx,
  output logic [NPORT*XLEN-1:0] o_wb_wdata
);

  localparam int W  = RFIDXW + XLEN;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [NCH-1:0]  full, empty, push, pop;
  logic [NCH-1:0]  kill, elig, lvl;
  logic [CW-1:0]   count [NCH];
  logic [W-1:0]    head [NCH];
  logic [PW-1:0]   ptr_q, ptr_d;
  logic            taken_q, taken_d;
  logic [XLEN-1:0] jaddr_q, jaddr_d;

  assign kill = i_flush ? FLUSHMASK : '0;
  assign elig = ~empty & ~kill;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    wb_chan_fifo #(
      .DEPTH(DEPTH),
      .W    (W)
    ) u_fifo (
      .i_clk (i_clk),
      .i_rstn(i_rstn),
      .push  (push[c]),
      .pop   (pop[c]),
      .clr   (kill[c]),
      .wdata ({i_ch_rdidx[c*RFIDXW +: RFIDXW],
               i_ch_wdata[c*XLEN +: XLEN]}),
      .full  (full[c]),
      .empty (empty[c]),
      .count (count[c]),
      .head  (head[c])
    );
    assign lvl[c] = (count[c] >= CW'(DEPTH - 1)) & i_ch_valid[c];
  end

  // a pop frees the slot this cycle, so a full queue can still accept
  assign o_ch_ready = ~full | pop;
  assign push       = i_ch_valid & o_ch_ready & ~kill;
  assign o_wait     = (|lvl) & ~i_flush;

  always_comb begin
    int c;
    int used;
    logic stop;
    logic [RFIDXW-1:0] idx;
    logic [RFIDXW-1:0] idx0;
    pop        = '0;
    o_wb_wen   = '0;
    o_wb_rdidx = '0;
    o_wb_wdata = '0;
    ptr_d      = ptr_q;
    c          = 0;
    used       = 0;
    stop       = 1'b0;
    idx        = '0;
    idx0       = '0;
    for (int i = 0; i < NCH; i++) begin
      c = (PRIO_MODE == WB_PRIO_RR) ?
          rr_chan(int'(ptr_q), i, NCH) : NCH - 1 - i;
      idx = head[c][W-1 -: RFIDXW];
      if (elig[c]) begin
        // x0 heads drain without a port
        if (idx == '0) begin
          pop[c] = 1'b1;
        end else if (!stop && used < NPORT) begin
          // same rd as port 0: defer, leave port 1 idle
          if (used == 1 && idx == idx0) begin
            stop = 1'b1;
          end else begin
            o_wb_wen[used] = 1'b1;
            o_wb_rdidx[used*RFIDXW +: RFIDXW] = idx;
            o_wb_wdata[used*XLEN +: XLEN] = head[c][XLEN-1:0];
            if (used == 0) idx0 = idx;
            pop[c] = 1'b1;
            ptr_d  = PW'(c);
            used++;
          end
        end
      end
    end
  end

  always_comb begin
    taken_d = i_flush ? 1'b0 : i_exu_taken;
    jaddr_d = i_exu_jaddr;
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      ptr_q   <= '0;
      taken_q <= 1'b0;
      jaddr_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      taken_q <= taken_d;
      jaddr_q <= jaddr_d;
    end
  end

  assign o_exu_taken = taken_q;
  assign o_exu_jaddr = jaddr_q;

endmodule
